player_motion: RTL and testbench

PLAYER_MOTION -- requirements
Module: player_motion

---
 rtl/player_motion.sv | 232 +++++++++++++++++++++++
 tb/tb_player_motion.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Player sprite motion: frame-strobe synchronizer, horizontal walking with
// clamping, and a GROUND/JUMP/FALL vertical state machine with gravity.
module player_motion #(
   parameter int X_START  = 64,
   parameter int Y_START  = 415,
   parameter int PLAYER_W = 32,
   parameter int PLAYER_H = 48,
   parameter int X_STEP   = 2,
   parameter int JUMP_V   = -8,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 6
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_jump,
   input  logic [9:0] player_X_Min,
   input  logic [9:0] player_X_Max,
   input  logic [9:0] player_Y_Min,
   input  logic [9:0] player_Y_Max,
   output logic [9:0] player_X_Pos,
   output logic [9:0] player_Y_Pos,
   output logic       on_ground,
   output logic       facing,
   output logic       frame_update
);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_JUMP   = 2'd1,
      ST_FALL   = 2'd2
   } state_t;

   localparam logic signed [11:0] PLAYER_W_S = 12'(PLAYER_W);
   localparam logic signed [11:0] PLAYER_H_S = 12'(PLAYER_H);
   localparam logic signed [11:0] X_STEP_S   = 12'(X_STEP);
   localparam logic signed [11:0] JUMP_V_S   = 12'(JUMP_V);
   localparam logic signed [11:0] GRAVITY_S  = 12'(GRAVITY);
   localparam logic signed [11:0] MAX_FALL_S = 12'(MAX_FALL);
   localparam logic signed [5:0]  JUMP_V6    = 6'(JUMP_V);

   logic              sync1_r, sync2_r, prev_r;
   logic              rdy1_r, rdy2_r, armed_r;
   logic              tick_s;

   logic [9:0]        x_r, y_r;
   logic signed [5:0] y_vel_r;
   state_t            state_r;
   logic              facing_r, on_ground_r, frame_update_r;

   logic [9:0]        x_n_s, y_n_s;
   logic signed [5:0] y_vel_n_s;
   state_t            state_n_s;
   logic              facing_n_s;

   logic signed [11:0] x_cur_s, x_lo_s, x_hi_s, x_cand_s;
   logic signed [11:0] y_cur_s, y_lo_s, y_hi_s, y_cand_s;
   logic signed [11:0] vel_s, grav_vel_s, fall_vel_s;

   // Frame strobe synchronizer; armed_r blocks a tick until a genuine low
   // sample has been seen after reset, so a level held high through reset
   // cannot produce a spurious first tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
         rdy1_r  <= 1'b0;
         rdy2_r  <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= frame_clk;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         rdy1_r  <= 1'b1;
         rdy2_r  <= rdy1_r;
         armed_r <= armed_r | (rdy2_r & ~sync2_r);
      end
   end

   assign tick_s = sync2_r & ~prev_r & armed_r;

   assign x_cur_s    = {2'b00, x_r};
   assign x_lo_s     = {2'b00, player_X_Min};
   assign x_hi_s     = $signed({2'b00, player_X_Max}) - PLAYER_W_S;
   assign y_cur_s    = {2'b00, y_r};
   assign y_lo_s     = {2'b00, player_Y_Min};
   assign y_hi_s     = $signed({2'b00, player_Y_Max}) - PLAYER_H_S;
   assign vel_s      = {{6{y_vel_r[5]}}, y_vel_r};
   assign grav_vel_s = vel_s + GRAVITY_S;
   assign fall_vel_s = (grav_vel_s > MAX_FALL_S) ? MAX_FALL_S : grav_vel_s;

   // Horizontal step and facing, clamped into the legal X range.
   always_comb begin
      x_n_s      = x_r;
      facing_n_s = facing_r;
      x_cand_s   = x_cur_s;
      if (key_left && !key_right) begin
         x_cand_s   = x_cur_s - X_STEP_S;
         facing_n_s = 1'b1;
      end else if (key_right && !key_left) begin
         x_cand_s   = x_cur_s + X_STEP_S;
         facing_n_s = 1'b0;
      end else begin
         x_cand_s   = x_cur_s;
      end
      if (x_lo_s > x_hi_s) begin
         x_n_s = x_r;
      end else if (x_cand_s < x_lo_s) begin
         x_n_s = x_lo_s[9:0];
      end else if (x_cand_s > x_hi_s) begin
         x_n_s = x_hi_s[9:0];
      end else begin
         x_n_s = x_cand_s[9:0];
      end
   end

   // Vertical next-state, velocity and position.
   always_comb begin
      y_n_s     = y_r;
      y_vel_n_s = y_vel_r;
      state_n_s = state_r;
      y_cand_s  = y_cur_s;
      if (y_lo_s > y_hi_s) begin
         y_n_s     = y_r;
         y_vel_n_s = 6'sd0;
         state_n_s = state_r;
      end else begin
         case (state_r)
            ST_GROUND: begin
               if (key_jump) begin
                  y_cand_s = y_cur_s + JUMP_V_S;
                  if (y_cand_s <= y_lo_s) begin
                     y_n_s     = y_lo_s[9:0];
                     y_vel_n_s = 6'sd0;
                     state_n_s = ST_FALL;
                  end else if (y_cand_s > y_hi_s) begin
                     y_n_s     = y_hi_s[9:0];
                     y_vel_n_s = JUMP_V6;
                     state_n_s = ST_JUMP;
                  end else begin
                     y_n_s     = y_cand_s[9:0];
                     y_vel_n_s = JUMP_V6;
                     state_n_s = ST_JUMP;
                  end
               end else if (y_cur_s < y_hi_s) begin
                  y_n_s     = (y_cur_s < y_lo_s) ? y_lo_s[9:0] : y_r;
                  y_vel_n_s = 6'sd0;
                  state_n_s = ST_FALL;
               end else begin
                  y_n_s     = y_hi_s[9:0];
                  y_vel_n_s = 6'sd0;
                  state_n_s = ST_GROUND;
               end
            end
            ST_JUMP: begin
               y_cand_s = y_cur_s + grav_vel_s;
               if (y_cand_s <= y_lo_s) begin
                  y_n_s     = y_lo_s[9:0];
                  y_vel_n_s = 6'sd0;
                  state_n_s = ST_FALL;
               end else if (y_cand_s >= y_hi_s) begin
                  y_n_s     = y_hi_s[9:0];
                  y_vel_n_s = 6'sd0;
                  state_n_s = ST_GROUND;
               end else begin
                  y_n_s     = y_cand_s[9:0];
                  y_vel_n_s = grav_vel_s[5:0];
                  if (grav_vel_s[11] == 1'b0) begin
                     state_n_s = ST_FALL;
                  end else begin
                     state_n_s = ST_JUMP;
                  end
               end
            end
            ST_FALL: begin
               y_cand_s = y_cur_s + fall_vel_s;
               if (y_cand_s >= y_hi_s) begin
                  y_n_s     = y_hi_s[9:0];
                  y_vel_n_s = 6'sd0;
                  state_n_s = ST_GROUND;
               end else if (y_cand_s < y_lo_s) begin
                  y_n_s     = y_lo_s[9:0];
                  y_vel_n_s = fall_vel_s[5:0];
                  state_n_s = ST_FALL;
               end else begin
                  y_n_s     = y_cand_s[9:0];
                  y_vel_n_s = fall_vel_s[5:0];
                  state_n_s = ST_FALL;
               end
            end
            default: begin
               y_n_s     = y_r;
               y_vel_n_s = 6'sd0;
               state_n_s = ST_GROUND;
            end
         endcase
      end
   end

   // Motion registers load only on a tick; frame_update marks that edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_r            <= 10'(X_START);
         y_r            <= 10'(Y_START);
         y_vel_r        <= 6'sd0;
         state_r        <= ST_GROUND;
         facing_r       <= 1'b0;
         on_ground_r    <= 1'b1;
         frame_update_r <= 1'b0;
      end else if (tick_s) begin
         x_r            <= x_n_s;
         y_r            <= y_n_s;
         y_vel_r        <= y_vel_n_s;
         state_r        <= state_n_s;
         facing_r       <= facing_n_s;
         on_ground_r    <= (state_n_s == ST_GROUND);
         frame_update_r <= 1'b1;
      end else begin
         frame_update_r <= 1'b0;
      end
   end

   assign player_X_Pos = x_r;
   assign player_Y_Pos = y_r;
   assign on_ground    = on_ground_r;
   assign facing       = facing_r;
   assign frame_update = frame_update_r;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: walking, jump arc, clamps, ceiling,
// floor drop, inverted ranges and reset colliding with a tick.
module tb_player_motion;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk, key_left, key_right, key_jump;
   logic [9:0] x_min, x_max, y_min, y_max;
   logic [9:0] x_pos, y_pos;
   logic       on_ground, facing, frame_update;

   int checks = 0;
   int errors = 0;

   player_motion dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
      .player_X_Min(x_min), .player_X_Max(x_max),
      .player_Y_Min(y_min), .player_Y_Max(y_max),
      .player_X_Pos(x_pos), .player_Y_Pos(y_pos),
      .on_ground(on_ground), .facing(facing), .frame_update(frame_update)
   );

   always #5 Clk = ~Clk;

   task automatic do_reset();
      Reset = 1'b1; frame_clk = 1'b0;
      key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
      x_min = 10'd19; x_max = 10'd620; y_min = 10'd30; y_max = 10'd463;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   // One frame strobe; waits (bounded) for the update pulse.
   task automatic do_tick(input string tag);
      bit seen;
      seen = 1'b0;
      frame_clk = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (frame_update) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL tick_timeout %s: frame_update=0 required 1", tag);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (x_pos !== 10'd64 || y_pos !== 10'd415 || on_ground !== 1'b1 ||
          facing !== 1'b0 || frame_update !== 1'b0) begin
         errors++;
         $display("FAIL reset: x=%0d y=%0d g=%b f=%b u=%b required 64 415 1 0 0",
                  x_pos, y_pos, on_ground, facing, frame_update);
      end
   endtask

   task automatic test_walk();
      int exp_x;
      key_right = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         do_tick("walk_right");
         exp_x = 64 + 2 * i;
         checks++;
         if (x_pos !== 10'(exp_x) || facing !== 1'b0 || y_pos !== 10'd415 || on_ground !== 1'b1) begin
            errors++;
            $display("FAIL walk_right %0d: x=%0d f=%b y=%0d g=%b required %0d 0 415 1",
                     i, x_pos, facing, y_pos, on_ground, exp_x);
         end
      end
      key_right = 1'b0; key_left = 1'b1;
      do_tick("walk_left");
      checks++;
      if (x_pos !== 10'd68 || facing !== 1'b1) begin
         errors++;
         $display("FAIL walk_left: x=%0d f=%b required 68 1", x_pos, facing);
      end
      key_right = 1'b1;
      do_tick("walk_both");
      checks++;
      if (x_pos !== 10'd68 || facing !== 1'b1) begin
         errors++;
         $display("FAIL walk_both: x=%0d f=%b required 68 1", x_pos, facing);
      end
      key_left = 1'b0; key_right = 1'b0;
   endtask

   task automatic test_jump();
      int seq [17] = '{400, 394, 389, 385, 382, 380, 379, 379,
                       380, 382, 385, 389, 394, 400, 406, 412, 415};
      do_reset();
      key_jump = 1'b1;
      do_tick("jump_launch");
      key_jump = 1'b0;
      checks++;
      if (y_pos !== 10'd407 || on_ground !== 1'b0) begin
         errors++;
         $display("FAIL jump_launch: y=%0d g=%b required 407 0", y_pos, on_ground);
      end
      for (int i = 0; i < 17; i++) begin
         do_tick("jump_arc");
         checks++;
         if (y_pos !== 10'(seq[i]) || on_ground !== (i == 16)) begin
            errors++;
            $display("FAIL jump_arc tick %0d: y=%0d g=%b required %0d %b",
                     i + 2, y_pos, on_ground, seq[i], (i == 16));
         end
      end
   endtask

   task automatic test_clamp_x();
      do_reset();
      key_left = 1'b1;
      for (int i = 0; i < 22; i++) do_tick("walk_to_20");
      checks++;
      if (x_pos !== 10'd20) begin
         errors++;
         $display("FAIL walk_to_20: x=%0d required 20", x_pos);
      end
      for (int i = 0; i < 2; i++) begin
         do_tick("clamp_left");
         checks++;
         if (x_pos !== 10'd19 || facing !== 1'b1) begin
            errors++;
            $display("FAIL clamp_left %0d: x=%0d f=%b required 19 1", i, x_pos, facing);
         end
      end
      key_left = 1'b0; x_min = 10'd40;
      do_tick("clamp_raised_min");
      checks++;
      if (x_pos !== 10'd40) begin
         errors++;
         $display("FAIL clamp_raised_min: x=%0d required 40", x_pos);
      end
      x_min = 10'd19; x_max = 10'd50; key_right = 1'b1;
      do_tick("x_inverted");
      checks++;
      if (x_pos !== 10'd40) begin
         errors++;
         $display("FAIL x_inverted: x=%0d required 40", x_pos);
      end
      key_right = 1'b0; x_max = 10'd620;
   endtask

   task automatic test_ceiling();
      do_reset();
      y_min = 10'd410; key_jump = 1'b1;
      do_tick("ceiling");
      key_jump = 1'b0;
      checks++;
      if (y_pos !== 10'd410 || on_ground !== 1'b0) begin
         errors++;
         $display("FAIL ceiling: y=%0d g=%b required 410 0", y_pos, on_ground);
      end
      do_tick("ceiling_fall");
      checks++;
      if (y_pos !== 10'd411) begin
         errors++;
         $display("FAIL ceiling_fall: y=%0d required 411", y_pos);
      end
      y_min = 10'd420;
      do_tick("y_inverted");
      checks++;
      if (y_pos !== 10'd411 || on_ground !== 1'b0) begin
         errors++;
         $display("FAIL y_inverted: y=%0d g=%b required 411 0", y_pos, on_ground);
      end
      y_min = 10'd30;
      do_tick("y_vel_zeroed");
      checks++;
      if (y_pos !== 10'd412) begin
         errors++;
         $display("FAIL y_vel_zeroed: y=%0d required 412", y_pos);
      end
   endtask

   task automatic test_floor_and_reset_tick();
      bit seen;
      do_reset();
      key_jump = 1'b1;
      do_tick("fj_launch");
      key_jump = 1'b0;
      for (int i = 0; i < 9; i++) do_tick("fj_arc");
      checks++;
      if (y_pos !== 10'd380 || on_ground !== 1'b0) begin
         errors++;
         $display("FAIL floor_pre: y=%0d g=%b required 380 0", y_pos, on_ground);
      end
      y_max = 10'd399; key_left = 1'b1;
      do_tick("floor_drop");
      key_left = 1'b0;
      checks++;
      if (y_pos !== 10'd351 || on_ground !== 1'b1 || x_pos !== 10'd62 || facing !== 1'b1) begin
         errors++;
         $display("FAIL floor_drop: y=%0d g=%b x=%0d f=%b required 351 1 62 1",
                  y_pos, on_ground, x_pos, facing);
      end
      // Reset lands exactly on the cycle the tick is visible inside the DUT.
      seen = 1'b0;
      frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1; y_max = 10'd463;
      repeat (3) begin
         @(negedge Clk);
         if (frame_update) seen = 1'b1;
      end
      Reset = 1'b0;
      repeat (6) begin
         @(negedge Clk);
         if (frame_update) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_tick_pulse: frame_update=1 required 0");
      end
      checks++;
      if (x_pos !== 10'd64 || y_pos !== 10'd415 || on_ground !== 1'b1 || facing !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick_values: x=%0d y=%0d g=%b f=%b required 64 415 1 0",
                  x_pos, y_pos, on_ground, facing);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      key_right = 1'b1;
      do_tick("post_reset");
      key_right = 1'b0;
      checks++;
      if (x_pos !== 10'd66 || y_pos !== 10'd415 || on_ground !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: x=%0d y=%0d g=%b required 66 415 1",
                  x_pos, y_pos, on_ground);
      end
   endtask

   initial begin
      test_reset();
      test_walk();
      test_jump();
      test_clamp_x();
      test_ceiling();
      test_floor_and_reset_tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
